scoreboard_mp: RTL and testbench

//  Parametrised multi-writeback register scoreboard for the CGRA dispatcher. Holds one reservation
//  row of NUM_REGS bits per thread ID. Issue reserves a row's bits, load writebacks release them,
//  and a read port reports RAW collision for a candidate TID/register map. Adds N writeback ports,

---
 rtl/sb_pkg.sv | 12 +
 rtl/sb_if.sv | 36 +++
 rtl/sb_popcount.sv | 13 +
 rtl/scoreboard_mp.sv | 93 +++++++++
 tb/tb_scoreboard_mp.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared types, default sizes and register decode helper for the scoreboard
package sb_pkg;
  typedef enum logic {SB_IDLE, SB_FLUSH} sb_state_e;
  localparam int SB_NUM_TIDS = 256;
  localparam int SB_NUM_REGS = 34;
  localparam int SB_NUM_WB = 2;
  localparam int SB_MAX_REGS = 64;
  // One-hot register mask; out-of-range register numbers decode to nothing
  function automatic logic [SB_MAX_REGS-1:0] sb_onehot_reg(input int unsigned r, input int unsigned n);
    return (r < n) ? (SB_MAX_REGS'(1) << r) : '0;
  endfunction
endpackage

// File: rtl/sb_if.sv
// sb_if: query, reserve, writeback and flush bundle of the scoreboard
interface sb_if #(
  parameter int NUM_TIDS = sb_pkg::SB_NUM_TIDS,
  parameter int NUM_REGS = sb_pkg::SB_NUM_REGS,
  parameter int NUM_WB = sb_pkg::SB_NUM_WB
);
  localparam int TID_W = $clog2(NUM_TIDS);
  localparam int REG_W = $clog2(NUM_REGS);
  logic rd_valid;
  logic [TID_W-1:0] rd_tid;
  logic [NUM_REGS-1:0] rd_regs_map;
  logic collision;
  logic rsv_valid;
  logic rsv_ready;
  logic [TID_W-1:0] rsv_tid;
  logic [NUM_REGS-1:0] rsv_regs_map;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*NUM_TIDS-1:0] wb_tid_bitmap;
  logic [NUM_WB*REG_W-1:0] wb_reg;
  logic flush_req;
  logic flush_busy;
  logic flush_done;
  logic [TID_W:0] pending_cnt;
  logic err_double_rsv;
  logic err_spurious_wb;
  modport master (
    output rd_valid, rd_tid, rd_regs_map, rsv_valid, rsv_tid, rsv_regs_map,
           wb_valid, wb_tid_bitmap, wb_reg, flush_req,
    input  collision, rsv_ready, flush_busy, flush_done, pending_cnt, err_double_rsv, err_spurious_wb
  );
  modport slave (
    input  rd_valid, rd_tid, rd_regs_map, rsv_valid, rsv_tid, rsv_regs_map,
           wb_valid, wb_tid_bitmap, wb_reg, flush_req,
    output collision, rsv_ready, flush_busy, flush_done, pending_cnt, err_double_rsv, err_spurious_wb
  );
endinterface

// File: rtl/sb_popcount.sv
// sb_popcount: combinational population count of a W-bit vector
module sb_popcount #(
  parameter int W = 8
) (
  input  logic [W-1:0] vec_i,
  output logic [$clog2(W):0] cnt_o
);
  // Adder chain over all bits
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + ($clog2(W)+1)'(vec_i[i]);
  end
endmodule

// File: rtl/scoreboard_mp.sv
// scoreboard_mp: multi-writeback register scoreboard with bypass, paced flush and pending count; SB_ERR_CHECK_EN adds sticky error flags
module scoreboard_mp import sb_pkg::*; #(
  parameter int NUM_TIDS = SB_NUM_TIDS,
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int NUM_WB = SB_NUM_WB
) (
  input logic clk,
  input logic rst_n,
  sb_if.slave bus
);
  localparam int TID_W = $clog2(NUM_TIDS);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam logic [TID_W-1:0] LAST = TID_W'(NUM_TIDS-1);
  logic [NUM_REGS-1:0] row_q [NUM_TIDS];
  logic [NUM_REGS-1:0] row_d [NUM_TIDS];
  logic [NUM_REGS-1:0] clr [NUM_TIDS];
  logic [NUM_REGS-1:0] wb_oh [NUM_WB];
  logic [NUM_TIDS-1:0] nz_d;
  logic [TID_W:0] cnt_d, pending_q;
  logic [TID_W-1:0] idx_q;
  sb_state_e state_q;
  logic done_q, rsv_fire, flushing;
  assign flushing = state_q == SB_FLUSH;
  assign rsv_fire = bus.rsv_valid & bus.rsv_ready;
  assign bus.rsv_ready = ~flushing;
  assign bus.flush_busy = flushing;
  assign bus.flush_done = done_q;
  assign bus.pending_cnt = pending_q;
  assign bus.collision = bus.rd_valid & |(bus.rd_regs_map & row_q[bus.rd_tid] & ~clr[bus.rd_tid]);
  // Decode each port's released register into a row mask
  always_comb begin
    for (int p = 0; p < NUM_WB; p++)
      wb_oh[p] = bus.wb_valid[p] ? NUM_REGS'(sb_onehot_reg(32'(bus.wb_reg[p*REG_W +: REG_W]), NUM_REGS)) : '0;
  end
  // Per-row clear mask: OR of all ports naming this TID
  always_comb begin
    for (int t = 0; t < NUM_TIDS; t++) begin
      clr[t] = '0;
      for (int p = 0; p < NUM_WB; p++) clr[t] = clr[t] | (bus.wb_tid_bitmap[p*NUM_TIDS+t] ? wb_oh[p] : '0);
    end
  end
  // Next rows: clear then set (set wins); the row under the flush pointer is forced to zero
  always_comb begin
    for (int t = 0; t < NUM_TIDS; t++) begin
      row_d[t] = (flushing && idx_q == TID_W'(t)) ? '0 :
                 (row_q[t] & ~clr[t]) | ((rsv_fire && bus.rsv_tid == TID_W'(t)) ? bus.rsv_regs_map : '0);
      nz_d[t] = |row_d[t];
    end
  end
  sb_popcount #(.W(NUM_TIDS)) u_pop (.vec_i(nz_d), .cnt_o(cnt_d));
  // Table, pending count and flush sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '{default: '0};
      pending_q <= '0;
      state_q <= SB_IDLE;
      idx_q <= '0;
      done_q <= 1'b0;
    end else begin
      row_q <= row_d;
      pending_q <= cnt_d;
      state_q <= (!flushing && bus.flush_req) ? SB_FLUSH : (flushing && idx_q == LAST) ? SB_IDLE : state_q;
      idx_q <= flushing ? idx_q + 1'b1 : '0;
      done_q <= flushing && idx_q == LAST;
    end
  end
`ifdef SB_ERR_CHECK_EN
  logic dbl_d, spur_d, err_dbl_q, err_spur_q;
  // Double reserve on a live bit, or release of a bit that is not held
  always_comb begin
    dbl_d = rsv_fire & |(bus.rsv_regs_map & row_q[bus.rsv_tid] & ~clr[bus.rsv_tid]);
    spur_d = 1'b0;
    for (int t = 0; t < NUM_TIDS; t++)
      for (int p = 0; p < NUM_WB; p++)
        spur_d = spur_d | (bus.wb_tid_bitmap[p*NUM_TIDS+t] & |(wb_oh[p] & ~row_q[t]));
  end
  // Sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dbl_q <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      err_dbl_q <= err_dbl_q | dbl_d;
      err_spur_q <= err_spur_q | spur_d;
    end
  end
  assign bus.err_double_rsv = err_dbl_q;
  assign bus.err_spurious_wb = err_spur_q;
`else
  assign bus.err_double_rsv = 1'b0;
  assign bus.err_spurious_wb = 1'b0;
`endif
endmodule

// File: tb/tb_scoreboard_mp.sv
// tb_scoreboard_mp: directed self-checking bench for scoreboard_mp
module tb_scoreboard_mp;
  localparam int NT = 256;
  localparam int RW = 6;
`ifdef SB_ERR_CHECK_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int busy_cnt;
  sb_if bus ();
  scoreboard_mp dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    bus.rd_valid = 0; bus.rd_tid = '0; bus.rd_regs_map = '0;
    bus.rsv_valid = 0; bus.rsv_tid = '0; bus.rsv_regs_map = '0;
    bus.wb_valid = '0; bus.wb_tid_bitmap = '0; bus.wb_reg = '0; bus.flush_req = 0;
  endtask
  task automatic probe(input string tag, input int tid, input logic [33:0] map, input logic exp);
    bus.rd_valid = 1; bus.rd_tid = tid[7:0]; bus.rd_regs_map = map;
    #1;
    chk(tag, bus.collision, exp);
    bus.rd_valid = 0;
  endtask
  task automatic set_rsv(input int tid, input logic [33:0] map);
    bus.rsv_valid = 1; bus.rsv_tid = tid[7:0]; bus.rsv_regs_map = map;
  endtask
  task automatic rsv(input int tid, input logic [33:0] map);
    set_rsv(tid, map);
    step();
    bus.rsv_valid = 0;
  endtask
  task automatic set_wb(input int p, input int tid, input int r);
    bus.wb_valid[p] = 1'b1;
    bus.wb_tid_bitmap[p*NT+tid] = 1'b1;
    bus.wb_reg[p*RW +: RW] = r[5:0];
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle_in();
    #15;
    chk("rst_ready", bus.rsv_ready, 1);
    chk("rst_busy", bus.flush_busy, 0);
    chk("rst_done", bus.flush_done, 0);
    chk("rst_pending", bus.pending_cnt, 0);
    chk("rst_errs", {bus.err_double_rsv, bus.err_spurious_wb}, 0);
    rst_n = 1;
    step();
    probe("t1_empty", 5, 34'h3FFFFFFFF, 0);
    set_rsv(7, 34'hF0);
    probe("t2_rsv_not_visible", 7, 34'h10, 0);
    step();
    bus.rsv_valid = 0;
    probe("t2_hit", 7, 34'h10, 1);
    probe("t2_miss", 7, 34'h0F, 0);
    chk("t2_pending", bus.pending_cnt, 1);
    set_wb(0, 7, 4);
    probe("t3_bypass", 7, 34'h10, 0);
    probe("t3_other_bits", 7, 34'h20, 1);
    step();
    idle_in();
    probe("t3_cleared", 7, 34'h1F, 0);
    probe("t3_kept", 7, 34'hE0, 1);
    set_wb(1, 7, 40);
    step();
    idle_in();
    probe("t3_bad_reg_ignored", 7, 34'h20, 1);
    set_wb(0, 7, 5);
    set_wb(1, 7, 6);
    step();
    idle_in();
    probe("t3_two_ports", 7, 34'h60, 0);
    probe("t3_bit7", 7, 34'h80, 1);
    rsv(3, 34'h1);
    chk("t4_pending", bus.pending_cnt, 2);
    set_rsv(3, 34'h1);
    set_wb(0, 3, 0);
    set_wb(1, 3, 0);
    step();
    idle_in();
    probe("t4_set_wins", 3, 34'h1, 1);
    chk("t4_no_spur", bus.err_spurious_wb, 0);
    chk("t4_no_dbl", bus.err_double_rsv, 0);
    rsv(0, 34'h200000000);
    rsv(100, 34'h2);
    rsv(255, 34'h4);
    chk("t5_pending_pre", bus.pending_cnt, 5);
    bus.flush_req = 1;
    step();
    bus.flush_req = 0;
    chk("t5_ready_low", bus.rsv_ready, 0);
    busy_cnt = 0;
    while (bus.flush_busy && busy_cnt < 400) begin
      if (busy_cnt == 10) set_rsv(0, 34'h8);
      else bus.rsv_valid = 0;
      busy_cnt++;
      step();
    end
    bus.rsv_valid = 0;
    chk("t5_busy_len", busy_cnt, 256);
    chk("t5_done_pulse", bus.flush_done, 1);
    chk("t5_pending_zero", bus.pending_cnt, 0);
    step();
    chk("t5_done_low", bus.flush_done, 0);
    probe("t5_row0", 0, 34'h3FFFFFFFF, 0);
    probe("t5_row100", 100, 34'h3FFFFFFFF, 0);
    probe("t5_row255", 255, 34'h3FFFFFFFF, 0);
    probe("t5_row7", 7, 34'h3FFFFFFFF, 0);
    chk("t5_ready_back", bus.rsv_ready, 1);
    rsv(200, 34'h1);
    chk("t5_pending_200", bus.pending_cnt, 1);
    bus.flush_req = 1;
    step();
    bus.flush_req = 0;
    repeat (49) step();
    chk("t5_busy_mid", bus.flush_busy, 1);
    #3;
    rst_n = 0;
    #1;
    chk("t5_rst_busy", bus.flush_busy, 0);
    chk("t5_rst_ready", bus.rsv_ready, 1);
    chk("t5_rst_pending", bus.pending_cnt, 0);
    probe("t5_rst_row200", 200, 34'h3FFFFFFFF, 0);
    rst_n = 1;
    step();
    chk("t5_idle_after", bus.flush_busy, 0);
    rsv(9, 34'h2);
    chk("t6_dbl_first", bus.err_double_rsv, 0);
    rsv(9, 34'h2);
    chk("t6_dbl", bus.err_double_rsv, ERR);
    chk("t6_spur_before", bus.err_spurious_wb, 0);
    set_wb(0, 9, 5);
    step();
    idle_in();
    chk("t6_spur", bus.err_spurious_wb, ERR);
    step();
    chk("t6_dbl_sticky", bus.err_double_rsv, ERR);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
